// File: rtl/fetch_mem_ctrl.sv
// Instruction-fetch sequencer: FETCH/DECODE/MEM phase control, program counter,
// RAM strobe decode and RAM address-bus multiplexing between PC and register address.
module fetch_mem_ctrl #(
  parameter int         PC_WIDTH = 16,
  parameter logic [3:0] OP_LDR   = 4'b1000,
  parameter logic [3:0] OP_STR   = 4'b1001
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          OpCode,
  input  logic [31:0]         addressIn,
  output logic [PC_WIDTH-1:0] PCout,
  output logic                firstFetch,
  output logic                RW_Out,
  output logic                Add_bus_sel,
  output logic                LDR_sel,
  output logic [31:0]         addressOut
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          op_q, op_d;
  logic                fetch_q, fetch_d;
  logic                rw_q, rw_d;
  logic                bus_q, bus_d;
  logic                ldr_q, ldr_d;
  logic                is_mem_op_s;
  logic                unused_addr_hi_s;

  assign is_mem_op_s = (OpCode == OP_LDR) || (OpCode == OP_STR);

  // Outputs are produced as next-state values so that each one is a flop of the phase it belongs to.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    fetch_d = 1'b0;
    rw_d    = 1'b0;
    bus_d   = 1'b0;
    ldr_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = OpCode;
        if (is_mem_op_s) begin
          state_d = S_MEM;
          bus_d   = 1'b1;
          rw_d    = (OpCode == OP_STR);
          ldr_d   = (OpCode == OP_LDR);
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          fetch_d = 1'b1;
        end
      end
      S_MEM: begin
        state_d = S_FETCH;
        pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        fetch_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
        fetch_d = 1'b1;
      end
    endcase
  end

  // Phase, PC, latched opcode and output flops; reset lands directly on FETCH outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= {PC_WIDTH{1'b0}};
      op_q    <= 4'h0;
      fetch_q <= 1'b1;
      rw_q    <= 1'b0;
      bus_q   <= 1'b0;
      ldr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      fetch_q <= fetch_d;
      rw_q    <= rw_d;
      bus_q   <= bus_d;
      ldr_q   <= ldr_d;
    end
  end

  assign PCout       = pc_q;
  assign firstFetch  = fetch_q;
  assign RW_Out      = rw_q;
  assign Add_bus_sel = bus_q;
  assign LDR_sel     = ldr_q;

  // Only the low address bits reach RAM; the register address passes through combinationally in MEM.
  assign addressOut = bus_q ? {{(32-PC_WIDTH){1'b0}}, addressIn[PC_WIDTH-1:0]}
                            : {{(32-PC_WIDTH){1'b0}}, pc_q};

  assign unused_addr_hi_s = ^addressIn[31:PC_WIDTH];

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Directed and randomized bench for fetch_mem_ctrl against an instruction-level reference model.
module tb_fetch_mem_ctrl;

  localparam logic [3:0] OP_LDR = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;

  logic        clk;
  logic        rst;
  logic [3:0]  OpCode;
  logic [31:0] addressIn;
  logic [15:0] PCout;
  logic        firstFetch, RW_Out, Add_bus_sel, LDR_sel;
  logic [31:0] addressOut;
  logic [3:0]  PCout_s;
  logic        firstFetch_s, RW_Out_s, Add_bus_sel_s, LDR_sel_s;
  logic [31:0] addressOut_s;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase 0=fetch 1=decode 2=memory; m_pc counts retired instructions.
  int         m_ph;
  int         m_pc;
  logic [3:0] m_op;

  fetch_mem_ctrl dut (
    .clk_i(clk), .rst_i(rst), .OpCode(OpCode), .addressIn(addressIn),
    .PCout(PCout), .firstFetch(firstFetch), .RW_Out(RW_Out),
    .Add_bus_sel(Add_bus_sel), .LDR_sel(LDR_sel), .addressOut(addressOut)
  );

  fetch_mem_ctrl #(.PC_WIDTH(4)) dut_small (
    .clk_i(clk), .rst_i(rst), .OpCode(OpCode), .addressIn(addressIn),
    .PCout(PCout_s), .firstFetch(firstFetch_s), .RW_Out(RW_Out_s),
    .Add_bus_sel(Add_bus_sel_s), .LDR_sel(LDR_sel_s), .addressOut(addressOut_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0;
    m_pc = 0;
    m_op = 4'h0;
  endtask

  task automatic model_edge();
    if (m_ph == 0) begin
      m_ph = 1;
    end else if (m_ph == 1) begin
      m_op = OpCode;
      if (OpCode == OP_LDR || OpCode == OP_STR) m_ph = 2;
      else begin m_pc++; m_ph = 0; end
    end else begin
      m_pc++;
      m_ph = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic        e_mem;
    logic [15:0] e_pc;
    logic [3:0]  e_pc_s;
    e_mem  = (m_ph == 2);
    e_pc   = 16'(m_pc % 65536);
    e_pc_s = 4'(m_pc % 16);
    chk({tag, ".pc"},   {16'h0, PCout},      {16'h0, e_pc});
    chk({tag, ".ff"},   {31'h0, firstFetch}, {31'h0, (m_ph == 0)});
    chk({tag, ".bus"},  {31'h0, Add_bus_sel}, {31'h0, e_mem});
    chk({tag, ".rw"},   {31'h0, RW_Out},     {31'h0, e_mem && (m_op == OP_STR)});
    chk({tag, ".ldr"},  {31'h0, LDR_sel},    {31'h0, e_mem && (m_op == OP_LDR)});
    chk({tag, ".addr"}, addressOut, e_mem ? {16'h0, addressIn[15:0]} : {16'h0, e_pc});
    chk({tag, ".pc4"},  {28'h0, PCout_s},    {28'h0, e_pc_s});
    chk({tag, ".addr4"}, addressOut_s, e_mem ? {28'h0, addressIn[3:0]} : {28'h0, e_pc_s});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] addr, input string tag);
    OpCode    = op;
    addressIn = addr;
    #1;
    check_all(tag);
    tick();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    OpCode = 4'h0;
    addressIn = 32'h0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) step(4'b0001, $urandom, "alu");
    chk("alu_pc3", {16'h0, PCout}, 32'd3);

    step(OP_LDR, 32'h5555_0000, "ld_fetch");
    step(OP_LDR, 32'hABCD_0040, "ld_dec");
    OpCode = 4'($urandom);
    addressIn = 32'hABCD_0040;
    #1;
    chk("ld_addr", addressOut, 32'h0000_0040);
    chk("ld_bus", {31'h0, Add_bus_sel}, 32'd1);
    chk("ld_sel", {31'h0, LDR_sel}, 32'd1);
    chk("ld_rw", {31'h0, RW_Out}, 32'd0);
    chk("ld_pc", {16'h0, PCout}, 32'd3);
    check_all("ld_mem");
    tick();
    chk("ld_pc_after", {16'h0, PCout}, 32'd4);

    step(4'b0010, 32'h0, "st_fetch");
    step(OP_STR, 32'h0000_1234, "st_dec");
    OpCode = OP_STR;
    addressIn = 32'h0000_1234;
    #1;
    chk("st_rw", {31'h0, RW_Out}, 32'd1);
    chk("st_ldr", {31'h0, LDR_sel}, 32'd0);
    chk("st_addr", addressOut, 32'h0000_1234);
    check_all("st_mem");
    OpCode = 4'b0000;
    #2;
    chk("st_latch_rw", {31'h0, RW_Out}, 32'd1);
    tick();
    chk("st_one_cycle", {31'h0, RW_Out}, 32'd0);
    check_all("st_next");

    step(4'b0011, 32'h0, "rst_fetch");
    step(OP_STR, 32'h0000_0777, "rst_dec");
    addressIn = 32'h0000_0777;
    #1;
    chk("rst_pre_rw", {31'h0, RW_Out}, 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rw", {31'h0, RW_Out}, 32'd0);
    chk("rst_pc", {16'h0, PCout}, 32'd0);
    chk("rst_ff", {31'h0, firstFetch}, 32'd1);
    chk("rst_addr", addressOut, 32'd0);
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? OP_LDR : OP_STR;
      else op = 4'($urandom);
      step(op, $urandom, "rnd");
    end

    for (int i = 0; i < 200 && !(m_ph == 0 && (m_pc % 16) == 15); i++)
      step(4'b0100, $urandom, "wrap_run");
    chk("wrap_reached", {31'h0, (m_ph == 0 && (m_pc % 16) == 15)}, 32'd1);
    chk("wrap_pre_pc4", {28'h0, PCout_s}, 32'd15);
    step(4'b0100, 32'hFFFF_FFFF, "wrap_fetch");
    step(4'b0101, 32'hFFFF_FFFF, "wrap_dec");
    addressIn = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pc4", {28'h0, PCout_s}, 32'd0);
    chk("wrap_addr4", addressOut_s, 32'd0);
    check_all("wrap_fetch2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
